// File: rtl/rv32_seq_divider.sv
// rtl/rv32_seq_divider.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose: one shift-and-subtract step per cycle. The core stalls while busy
// is high and captures result in the cycle done pulses.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request pulse, accepted only when idle and not signalling done
//   op        funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  rs1 value, sampled with start
//   divisor   rs2 value, sampled with start
//   busy      operation in progress
//   done      one-cycle pulse, result valid this cycle
//   result    quotient or remainder, held until the next operation completes
module rv32_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  // FIX is the final busy cycle; the done pulse follows in IDLE.
  // ZERO is the single done cycle of a divide-by-zero.
  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             done_q, done_d;

  logic             sgn;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  assign sgn     = ~op[0];
  assign dvd_abs = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_abs = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Shifted partial remainder picks up the next dividend bit from the top of quo.
  // Trial is one bit wider than the shifted remainder so its MSB is a clean sign.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          op_d   = op;
          quo_d  = dvd_abs;
          dvs_d  = dvs_abs;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH);
          negq_d = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = sgn & dividend[WIDTH-1];
          if (divisor == '0) begin
            result_d = op[1] ? dividend : '1;
            done_d   = 1'b1;
            state_d  = ZERO;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = trial[WIDTH+1] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        result_d = op_q[1] ? (negr_q ? -rem_q : rem_q)
                           : (negq_q ? -quo_q : quo_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      ZERO: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv32_seq_divider.sv
// tb/tb_rv32_seq_divider.sv - self-checking bench for rv32_seq_divider
module tb_rv32_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  rv32_seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          done_cyc;
    int          extra_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is positioned #1 after a rising edge; that cycle is cycle 0.
  // extra_cyc > 0 pulses a second start with different operands in that cycle.
  task automatic run_op(input vec_t v);
    int cyc;
    bit seen;
    bit busy_bad;
    start = 1'b1; op = v.op; dividend = v.a; divisor = v.b;
    cyc = 0; seen = 1'b0; busy_bad = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == v.extra_cyc) begin
        start = 1'b1; op = OP_DIVU; dividend = 32'd77; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        check({v.name, " done_cycle"}, 32'(cyc), 32'(v.done_cyc));
        check({v.name, " result"}, result, v.exp);
        check({v.name, " busy_at_done"}, 32'(busy), 32'd0);
      end else if (busy !== (cyc < v.done_cyc)) begin
        busy_bad = 1'b1;
      end
    end
    if (!seen) check({v.name, " done_timeout"}, 32'd0, 32'd1);
    check({v.name, " busy_pattern"}, 32'(busy_bad), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check({v.name, " done_one_cycle"}, 32'(done), 32'd0);
    check({v.name, " busy_after"}, 32'(busy), 32'd0);
    check({v.name, " result_held"}, result, v.exp);
  endtask

  vec_t vecs[$];
  vec_t v;
  bit   stray_done;

  initial begin
    vecs.push_back('{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 0});
    vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          34, 0});
    vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0});
    vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0});
    vecs.push_back('{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 0});
    vecs.push_back('{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, 0});
    vecs.push_back('{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 0});
    vecs.push_back('{"divu_by0",     OP_DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1,  0});
    vecs.push_back('{"rem_by0",      OP_REM,  32'hFFFF_FF00,  32'd0,          32'hFFFF_FF00,  1,  1});
    vecs.push_back('{"divu_restart", OP_DIVU, 32'd1000,       32'd10,         32'd100,        34, 5});
    vecs.push_back('{"div_start_dn", OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34, 34});
    vecs.push_back('{"remu_big",     OP_REMU, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  34, 0});

    // Reset with start asserted: reset must win.
    rst = 1'b1; start = 1'b1; op = OP_DIVU; dividend = 32'd50; divisor = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset at cycle 10 of a DIV aborts it; result (non-zero before) clears.
    start = 1'b1; op = OP_DIV; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result,    32'd0);
    stray_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) stray_done = 1'b1;
    end
    check("abort_no_done", 32'(stray_done), 32'd0);

    v = '{"divu_ffff_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0};
    run_op(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
